// File: rtl/action_cfg_sched_if.sv
// Signal bundle for action_cfg_sched: the PHV stream from the match stage,
// the PHV/action stream to the crossbar, and the control-plane update port.
// master = the side that drives the stage (match stage / control plane),
// slave  = the scheduler itself.
interface action_cfg_sched_if #(
    parameter int PHV_LEN = 1124,
    parameter int ACT_LEN = 25,
    parameter int ACT_NUM = 25,
    parameter int ADDR_W  = 4
);
    // PHV stream in
    logic [PHV_LEN-1:0]         phv_in;
    logic                       phv_in_valid;
    logic [ADDR_W-1:0]          lookup_addr;
    logic                       lookup_hit;
    logic                       phv_in_ready;

    // PHV/action stream out
    logic [PHV_LEN-1:0]         phv_out;
    logic [ACT_LEN*ACT_NUM-1:0] action_out;
    logic                       phv_out_valid;
    logic                       phv_out_ready;

    // Control-plane table update
    logic                       cfg_sub_valid;
    logic [4:0]                 cfg_slot;
    logic [ACT_LEN-1:0]         cfg_sub_data;
    logic                       cfg_commit;
    logic [ADDR_W-1:0]          cfg_addr;
    logic                       cfg_ready;
    logic                       cfg_done;
    logic                       cfg_err;

    modport master (
        output phv_in, phv_in_valid, lookup_addr, lookup_hit, phv_out_ready,
               cfg_sub_valid, cfg_slot, cfg_sub_data, cfg_commit, cfg_addr,
        input  phv_in_ready, phv_out, action_out, phv_out_valid,
               cfg_ready, cfg_done, cfg_err
    );

    modport slave (
        input  phv_in, phv_in_valid, lookup_addr, lookup_hit, phv_out_ready,
               cfg_sub_valid, cfg_slot, cfg_sub_data, cfg_commit, cfg_addr,
        output phv_in_ready, phv_out, action_out, phv_out_valid,
               cfg_ready, cfg_done, cfg_err
    );
endinterface

// File: rtl/action_cfg_sched.sv
// Per-stage action scheduler in front of the RMT action crossbar.
// Two-stage pipeline: S1 captures the matched PHV and lookup result, S2
// captures the PHV together with its action word read from the table.
// Control-plane writes are staged in a shadow word and committed to the
// table only once the pipeline has fully drained, so a packet never sees
// a partially updated action.
module action_cfg_sched #(
    parameter int PHV_LEN = 1124,
    parameter int ACT_LEN = 25,
    parameter int ACT_NUM = 25,
    parameter int ADDR_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    action_cfg_sched_if.slave  bus
);
    localparam int          ACT_W = ACT_LEN * ACT_NUM;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        WRITE
    } state_t;

    state_t state_q, state_d;

    // Low while in reset and for the partial cycle after release, so every
    // ready output reads 0 until the first clock edge out of reset.
    logic live_q;

    // S1: matched PHV and lookup result
    logic               s1_valid_q, s1_valid_d;
    logic [PHV_LEN-1:0] s1_phv_q,   s1_phv_d;
    logic [ADDR_W-1:0]  s1_addr_q,  s1_addr_d;
    logic               s1_hit_q,   s1_hit_d;

    // S2: PHV plus its action word
    logic               s2_valid_q, s2_valid_d;
    logic [PHV_LEN-1:0] s2_phv_q,   s2_phv_d;
    logic [ACT_W-1:0]   s2_act_q,   s2_act_d;

    // Action table and staging
    logic [ACT_W-1:0]   table_q [DEPTH];
    logic [ACT_W-1:0]   shadow_q, shadow_d;
    logic [ADDR_W-1:0]  caddr_q,  caddr_d;
    logic               done_q,   done_d;
    logic               err_q,    err_d;

    logic s2_free;
    logic in_ready;
    logic in_fire;
    logic cfg_rdy;
    logic sub_fire;
    logic commit_fire;
    logic slot_ok;

    // Handshake qualifiers shared by the pipeline and config logic
    always_comb begin
        s2_free     = !s2_valid_q || bus.phv_out_ready;
        in_ready    = live_q && (state_q == IDLE) && (!s1_valid_q || s2_free);
        in_fire     = in_ready && bus.phv_in_valid;
        cfg_rdy     = live_q && (state_q == IDLE);
        sub_fire    = cfg_rdy && bus.cfg_sub_valid;
        commit_fire = cfg_rdy && bus.cfg_commit;
        slot_ok     = int'(bus.cfg_slot) < ACT_NUM;
    end

    // Update FSM: drain the pipeline, then write the shadow into the table
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (commit_fire) state_d = DRAIN;
            DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = WRITE;
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // S1 next state: empties when S2 can take it, reloads on accept
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_phv_d   = s1_phv_q;
        s1_addr_d  = s1_addr_q;
        s1_hit_d   = s1_hit_q;
        if (s2_free) s1_valid_d = 1'b0;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_phv_d   = bus.phv_in;
            s1_addr_d  = bus.lookup_addr;
            s1_hit_d   = bus.lookup_hit;
        end
    end

    // S2 next state: table read on the S1->S2 transfer, hold while stalled
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_phv_d   = s2_phv_q;
        s2_act_d   = s2_act_q;
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_phv_d = s1_phv_q;
                s2_act_d = s1_hit_q ? table_q[s1_addr_q] : '0;
            end
        end
    end

    // Shadow slot writes, sticky bad-slot flag, commit address and done pulse
    always_comb begin
        shadow_d = shadow_q;
        err_d    = err_q;
        caddr_d  = caddr_q;
        done_d   = (state_q == WRITE);
        if (state_q == WRITE) begin
            shadow_d = '0;
        end else if (sub_fire) begin
            if (slot_ok) begin
                for (int unsigned k = 0; k < ACT_NUM; k++) begin
                    if (bus.cfg_slot == 5'(k)) shadow_d[k*ACT_LEN +: ACT_LEN] = bus.cfg_sub_data;
                end
            end else begin
                err_d = 1'b1;
            end
        end
        if (commit_fire) caddr_d = bus.cfg_addr;
    end

    // Control registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            shadow_q <= '0;
            caddr_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            shadow_q <= shadow_d;
            caddr_q  <= caddr_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_phv_q   <= '0;
            s1_addr_q  <= '0;
            s1_hit_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_phv_q   <= '0;
            s2_act_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_phv_q   <= s1_phv_d;
            s1_addr_q  <= s1_addr_d;
            s1_hit_q   <= s1_hit_d;
            s2_valid_q <= s2_valid_d;
            s2_phv_q   <= s2_phv_d;
            s2_act_q   <= s2_act_d;
        end
    end

    // Action table: cleared by reset, written only from WRITE (pipeline empty)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) table_q[i] <= '0;
        end else if (state_q == WRITE) begin
            table_q[caddr_q] <= shadow_q;
        end
    end

    assign bus.phv_in_ready  = in_ready;
    assign bus.phv_out       = s2_phv_q;
    assign bus.action_out    = s2_act_q;
    assign bus.phv_out_valid = s2_valid_q;
    assign bus.cfg_ready     = cfg_rdy;
    assign bus.cfg_done      = done_q;
    assign bus.cfg_err       = err_q;
endmodule
